// File: rtl/vga_pixel_fetch.sv
// Framebuffer prefetch stage: issues word reads for one frame and pops one RGB444 pixel per request.
// Optional build macro VGA_FETCH_TESTPAT_EN adds iTest_Pattern for 8 vertical colour bars.
module vga_pixel_fetch #(
   parameter int          ADDR_WIDTH      = 22,
   parameter int          FRAME_WORDS     = 307200,
   parameter int          FIFO_DEPTH      = 64,
   parameter int          MAX_PENDING     = 8,
   parameter logic [11:0] UNDERFLOW_COLOR = 12'hF0F
) (
   input  logic                          iCLK,
   input  logic                          iRST_N,
   input  logic                          iFrame_Start,
   input  logic [ADDR_WIDTH-1:0]         iFrame_Base,
   input  logic                          iRequest,
`ifdef VGA_FETCH_TESTPAT_EN
   input  logic                          iTest_Pattern,
`endif
   output logic [3:0]                    oRed,
   output logic [3:0]                    oGreen,
   output logic [3:0]                    oBlue,
   output logic [ADDR_WIDTH-1:0]         oMem_Address,
   output logic                          oMem_Read,
   input  logic                          iMem_WaitRequest,
   input  logic [15:0]                   iMem_ReadData,
   input  logic                          iMem_ReadDataValid,
   output logic                          oUnderflow,
   output logic [$clog2(FIFO_DEPTH):0]   oFifo_Level
);

   localparam int FC_W   = $clog2(FRAME_WORDS + 1);
   localparam int PEND_W = $clog2(MAX_PENDING + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam logic [FC_W-1:0]   FC_END    = FC_W'(FRAME_WORDS);
   localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
   localparam logic [LVL_W:0]    DEPTH_SUM = (LVL_W + 1)'(FIFO_DEPTH);

   logic [FC_W-1:0]       fetch_count_q, fetch_count_d;
   logic [PEND_W-1:0]     pending_q, pending_d;
   logic [PEND_W-1:0]     discard_q, discard_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic                  stale_q, stale_d;
   logic                  mem_read_q, mem_read_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic [11:0]           pixel_q, pixel_d;
   logic                  underflow_q, underflow_d;
   logic [11:0]           fifo_mem [FIFO_DEPTH];

   logic accept, drop, push, fifo_pop, tp_mode;
   logic unused_ok;

   assign unused_ok = &{1'b0, iMem_ReadData[15:12]};

`ifdef VGA_FETCH_TESTPAT_EN
   logic [6:0] col_q, col_d;
   logic [2:0] bar_q, bar_d;

   assign tp_mode = iTest_Pattern;

   always_comb begin
      col_d = col_q;
      bar_d = bar_q;
      if (iFrame_Start) begin
         col_d = '0;
         bar_d = '0;
      end else if (iRequest) begin
         if (col_q == 7'd79) begin
            col_d = '0;
            bar_d = bar_q + 3'd1;
         end else begin
            col_d = col_q + 7'd1;
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         col_q <= '0;
         bar_q <= '0;
      end else begin
         col_q <= col_d;
         bar_q <= bar_d;
      end
   end
`else
   assign tp_mode = 1'b0;
`endif

   always_comb begin
      accept    = mem_read_q & ~iMem_WaitRequest;
      drop      = iMem_ReadDataValid & (discard_q != '0);
      push      = iMem_ReadDataValid & ~drop & ~iFrame_Start;
      fifo_pop  = iRequest & ~iFrame_Start & ~tp_mode & (level_q != '0);
      pending_d = pending_q + PEND_W'(accept) - PEND_W'(iMem_ReadDataValid);

      fetch_count_d = fetch_count_q;
      discard_d     = discard_q;
      base_d        = base_q;
      stale_d       = stale_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      level_d       = level_q;
      pixel_d       = pixel_q;
      underflow_d   = underflow_q;

      // A read stalled across a frame restart is finished with its old address, then thrown away.
      if (iFrame_Start) begin
         fetch_count_d = '0;
         base_d        = iFrame_Base;
         discard_d     = pending_d;
         stale_d       = mem_read_q & iMem_WaitRequest;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         level_d       = '0;
      end else begin
         fetch_count_d = fetch_count_q + FC_W'(accept & ~stale_q);
         discard_d     = discard_q - PEND_W'(drop) + PEND_W'(accept & stale_q);
         if (accept) stale_d = 1'b0;
         wr_ptr_d      = wr_ptr_q + PTR_W'(push);
         rd_ptr_d      = rd_ptr_q + PTR_W'(fifo_pop);
         level_d       = level_q + LVL_W'(push) - LVL_W'(fifo_pop);
      end

      if (mem_read_q & iMem_WaitRequest) begin
         mem_read_d = 1'b1;
         mem_addr_d = mem_addr_q;
      end else begin
         mem_read_d = (fetch_count_d < FC_END) && (pending_d < PEND_MAX) &&
                      (({1'b0, level_d} + (LVL_W + 1)'(pending_d)) < DEPTH_SUM);
         mem_addr_d = base_d + ADDR_WIDTH'(fetch_count_d);
      end

      if (iRequest) begin
         if (iFrame_Start) begin
            pixel_d = UNDERFLOW_COLOR;
`ifdef VGA_FETCH_TESTPAT_EN
         end else if (iTest_Pattern) begin
            pixel_d = {{4{bar_q[2]}}, {4{bar_q[1]}}, {4{bar_q[0]}}};
`endif
         end else if (level_q == '0) begin
            pixel_d     = UNDERFLOW_COLOR;
            underflow_d = 1'b1;
         end else begin
            pixel_d = fifo_mem[rd_ptr_q];
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (push) fifo_mem[wr_ptr_q] <= iMem_ReadData[11:0];
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         fetch_count_q <= FC_END;
         pending_q     <= '0;
         discard_q     <= '0;
         base_q        <= '0;
         stale_q       <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_addr_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         pixel_q       <= '0;
         underflow_q   <= 1'b0;
      end else begin
         fetch_count_q <= fetch_count_d;
         pending_q     <= pending_d;
         discard_q     <= discard_d;
         base_q        <= base_d;
         stale_q       <= stale_d;
         mem_read_q    <= mem_read_d;
         mem_addr_q    <= mem_addr_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         pixel_q       <= pixel_d;
         underflow_q   <= underflow_d;
      end
   end

   assign oRed         = pixel_q[11:8];
   assign oGreen       = pixel_q[7:4];
   assign oBlue        = pixel_q[3:0];
   assign oMem_Address = mem_addr_q;
   assign oMem_Read    = mem_read_q;
   assign oUnderflow   = underflow_q;
   assign oFifo_Level  = level_q;

endmodule
